alu_result_stage: RTL and testbench

EX/MEM boundary stage directly downstream of the 64-bit ALU. Captures ALU result, Zero_Flag and Overflow together with the issuing opcode and destination tag through a valid/ready handshake. Buffers results in a 2-entry skid queue so that writeback back-pressure never corrupts an in-flight result. Maintains sticky overflow status and operation counters for debug readout.

---
 rtl/alu_result_stage.sv | 184 ++++++++++++++++++
 tb/tb_alu_result_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: EX/MEM boundary stage behind the 64-bit ALU.
//
// Captures the ALU result, its zero and overflow flags, the issuing opcode
// and the destination tag through a valid/ready handshake. Entries are held
// in a 2-entry queue so that writeback back-pressure never corrupts an
// in-flight result. A sticky overflow flag and two wrapping counters are
// kept for debug readout.
//
// Optional feature (macro ALU_RESULT_OVF_TRAP_EN):
//   Defined   - an accepted entry with alu_ovf=1 is not queued. It raises a
//               one-cycle trap_valid pulse at the next edge. trap_tag and
//               trap_op capture that entry's tag and opcode, and hold them
//               until the next trap.
//   Undefined - overflowing entries are queued like any other entry, and
//               trap_valid, trap_tag and trap_op are tied to 0.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   in_valid / in_ready     upstream handshake. in_ready depends only on the
//                           registered occupancy and on flush.
//   alu_out, alu_zero,      payload arriving from the ALU
//   alu_ovf, alu_op,
//   dst_tag
//   out_valid / out_ready   downstream handshake for the head entry
//   out_data, out_zero,     payload of the head entry
//   out_ovf, out_op,
//   out_tag
//   flush                   synchronous discard of all buffered entries
//   clr_status              synchronous clear of the sticky flag and both
//                           counters
//   ovf_sticky, op_count,   statistics for debug readout
//   ovf_count
//   trap_valid, trap_tag,   overflow trap report (optional feature)
//   trap_op

module alu_result_stage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  input  logic [OP_WIDTH-1:0]   alu_op,
  input  logic [TAG_WIDTH-1:0]  dst_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic [OP_WIDTH-1:0]   out_op,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  flush,
  input  logic                  clr_status,
  output logic                  ovf_sticky,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  output logic                  trap_valid,
  output logic [TAG_WIDTH-1:0]  trap_tag,
  output logic [OP_WIDTH-1:0]   trap_op
);

  localparam int unsigned OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  zero;
    logic                  ovf;
    logic [OP_WIDTH-1:0]   op;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  entry_t            mem [2];
  entry_t            in_entry;
  entry_t            head_entry;
  logic              head_ptr;
  logic              tail_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_nxt;
  logic              push_acc;
  logic              wr_en;
  logic              pop;

  // The handshake is decided from registered state only.
  assign in_ready  = (occ != OCC_FULL) && !flush;
  assign out_valid = (occ != OCC_EMPTY);
  assign push_acc  = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign in_entry = '{data: alu_out, zero: alu_zero, ovf: alu_ovf,
                      op: alu_op, tag: dst_tag};

`ifdef ALU_RESULT_OVF_TRAP_EN
  // Overflowing entries are diverted to the trap port instead of the queue.
  logic trap_hit;
  assign trap_hit = push_acc && alu_ovf;
  assign wr_en    = push_acc && !alu_ovf;
`else
  assign wr_en    = push_acc;
`endif

  // Occupancy never underflows because a pop requires out_valid. It never
  // overflows because a push at OCC_FULL is blocked by in_ready.
  assign occ_nxt = occ + OCC_W'(wr_en) - OCC_W'(pop);

  // Queue storage and pointers. The entries are cleared on reset so that
  // the out_* payload reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      occ      <= OCC_EMPTY;
    end else if (flush) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      occ      <= OCC_EMPTY;
    end else begin
      if (wr_en) begin
        mem[tail_ptr] <= in_entry;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      occ <= occ_nxt;
    end
  end

  // The head entry is a mux of registered storage, so there is no path from
  // the input to the output within a cycle.
  assign head_entry = mem[head_ptr];
  assign out_data   = head_entry.data;
  assign out_zero   = head_entry.zero;
  assign out_ovf    = head_entry.ovf;
  assign out_op     = head_entry.op;
  assign out_tag    = head_entry.tag;

  // Statistics. clr_status clears first, then an accepted push in the same
  // cycle is counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count   <= '0;
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      op_count   <= (clr_status ? '0 : op_count) + CNT_WIDTH'(push_acc);
      ovf_count  <= (clr_status ? '0 : ovf_count) +
                    CNT_WIDTH'(push_acc && alu_ovf);
      ovf_sticky <= (clr_status ? 1'b0 : ovf_sticky) | (push_acc && alu_ovf);
    end
  end

`ifdef ALU_RESULT_OVF_TRAP_EN
  // Trap report: a one-cycle pulse, with the tag and opcode held until the
  // next trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_valid <= 1'b0;
      trap_tag   <= '0;
      trap_op    <= '0;
    end else begin
      trap_valid <= trap_hit;
      if (trap_hit) begin
        trap_tag <= dst_tag;
        trap_op  <= alu_op;
      end
    end
  end
`else
  assign trap_valid = 1'b0;
  assign trap_tag   = '0;
  assign trap_op    = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, flush, clr_status;
  logic [63:0] alu_out;
  logic        alu_zero, alu_ovf;
  logic [3:0]  alu_op;
  logic [4:0]  dst_tag;

  logic        in_ready, out_valid, out_zero, out_ovf, ovf_sticky, trap_valid;
  logic [63:0] out_data;
  logic [3:0]  out_op, trap_op;
  logic [4:0]  out_tag, trap_tag;
  logic [31:0] op_count, ovf_count;

  // Second instance with 4-bit counters to exercise counter wrap.
  logic        in_ready4, out_valid4, out_zero4, out_ovf4, ovf_sticky4, trap_valid4;
  logic [63:0] out_data4;
  logic [3:0]  out_op4, trap_op4;
  logic [4:0]  out_tag4, trap_tag4;
  logic [3:0]  op_count4, ovf_count4;

  always #5 clk = ~clk;

  alu_result_stage u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_op(alu_op), .dst_tag(dst_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_op(out_op), .out_tag(out_tag), .flush(flush),
    .clr_status(clr_status), .ovf_sticky(ovf_sticky), .op_count(op_count),
    .ovf_count(ovf_count), .trap_valid(trap_valid), .trap_tag(trap_tag),
    .trap_op(trap_op)
  );

  alu_result_stage #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_op(alu_op), .dst_tag(dst_tag), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_zero(out_zero4),
    .out_ovf(out_ovf4), .out_op(out_op4), .out_tag(out_tag4), .flush(flush),
    .clr_status(clr_status), .ovf_sticky(ovf_sticky4), .op_count(op_count4),
    .ovf_count(ovf_count4), .trap_valid(trap_valid4), .trap_tag(trap_tag4),
    .trap_op(trap_op4)
  );

`ifdef ALU_RESULT_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Reference model: a queue of results plus plain integer statistics.
  typedef struct packed {
    logic [63:0] data;
    logic        zero;
    logic        ovf;
    logic [3:0]  op;
    logic [4:0]  tag;
  } tb_entry_t;

  tb_entry_t   q[$];
  logic [31:0] m_opc, m_ovc;
  bit          m_sticky, m_trap_v;
  logic [4:0]  m_trap_tag;
  logic [3:0]  m_trap_op;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_opc = '0; m_ovc = '0; m_sticky = 0;
    m_trap_v = 0; m_trap_tag = '0; m_trap_op = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit ir, acc, pop;
    tb_entry_t p;
    ir  = (q.size() < 2) && !flush;
    acc = in_valid && ir;
    pop = (q.size() > 0) && out_ready && !flush;
    p   = '{alu_out, alu_zero, alu_ovf, alu_op, dst_tag};
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc && !(TRAP && alu_ovf)) q.push_back(p);
    end
    if (clr_status) begin m_opc = 0; m_ovc = 0; m_sticky = 0; end
    if (acc) begin
      m_opc = m_opc + 1;
      if (alu_ovf) begin m_ovc = m_ovc + 1; m_sticky = 1; end
    end
    m_trap_v = TRAP && acc && alu_ovf;
    if (m_trap_v) begin m_trap_tag = dst_tag; m_trap_op = alu_op; end
  endtask

  task automatic compare_model();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !flush));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_flags", {62'd0, out_zero, out_ovf}, {62'd0, q[0].zero, q[0].ovf});
      chk("out_op_tag", {55'd0, out_op, out_tag}, {55'd0, q[0].op, q[0].tag});
    end
    chk("op_count", 64'(op_count), 64'(m_opc));
    chk("ovf_count", 64'(ovf_count), 64'(m_ovc));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    chk("trap_valid", 64'(trap_valid), 64'(m_trap_v));
    chk("trap_tag_op", {55'd0, trap_op, trap_tag}, {55'd0, m_trap_op, m_trap_tag});
    chk("op_count4", 64'(op_count4), 64'(m_opc[3:0]));
    chk("ovf_count4", 64'(ovf_count4), 64'(m_ovc[3:0]));
    chk("out_valid4", 64'(out_valid4), 64'(q.size() != 0));
  endtask

  task automatic cycle(input bit do_chk);
    @(negedge clk);
    if (do_chk) compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; clr_status = 0;
    alu_out = '0; alu_zero = 0; alu_ovf = 0; alu_op = '0; dst_tag = '0;
  endtask

  // Directed vectors. Each row is applied for one cycle, and its
  // expectations describe the state just before that row's clock edge.
  typedef struct {
    bit          iv, orr, fl, clr;
    logic [63:0] d;
    logic [4:0]  tag;
    bit          ev;
    logic [63:0] ed;
    bit          eir;
    int          eopc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // single push
    tbl[0]  = '{1, 1, 0, 0, 64'd4,  5'd3, 0, 64'd0,  1, 0};
    tbl[1]  = '{0, 1, 0, 0, 64'd0,  5'd0, 1, 64'd4,  1, 1};
    // back-pressure: 2 then 35, then a blocked push of 99
    tbl[2]  = '{1, 0, 0, 0, 64'd2,  5'd1, 0, 64'd0,  1, 1};
    tbl[3]  = '{1, 0, 0, 0, 64'd35, 5'd2, 1, 64'd2,  1, 2};
    tbl[4]  = '{1, 0, 0, 0, 64'd99, 5'd4, 1, 64'd2,  0, 3};
    tbl[5]  = '{0, 1, 0, 0, 64'd0,  5'd0, 1, 64'd2,  0, 3};
    tbl[6]  = '{0, 1, 0, 0, 64'd0,  5'd0, 1, 64'd35, 1, 3};
    // streaming 1,2,3 with simultaneous push/pop
    tbl[7]  = '{1, 1, 0, 0, 64'd1,  5'd5, 0, 64'd0,  1, 3};
    tbl[8]  = '{1, 1, 0, 0, 64'd2,  5'd6, 1, 64'd1,  1, 4};
    tbl[9]  = '{1, 1, 0, 0, 64'd3,  5'd7, 1, 64'd2,  1, 5};
    tbl[10] = '{0, 1, 0, 0, 64'd0,  5'd0, 1, 64'd3,  1, 6};
    // flush with two entries queued and in_valid high
    tbl[11] = '{1, 0, 0, 0, 64'd10, 5'd8, 0, 64'd0,  1, 6};
    tbl[12] = '{1, 0, 0, 0, 64'd11, 5'd9, 1, 64'd10, 1, 7};
    tbl[13] = '{1, 1, 1, 0, 64'd12, 5'd9, 1, 64'd10, 0, 8};
    tbl[14] = '{0, 0, 0, 0, 64'd0,  5'd0, 0, 64'd0,  1, 8};
    // clr_status coinciding with a push
    tbl[15] = '{1, 0, 0, 1, 64'd5,  5'd2, 0, 64'd0,  1, 8};
    tbl[16] = '{0, 1, 0, 0, 64'd0,  5'd0, 1, 64'd5,  1, 1};
    tbl[17] = '{0, 0, 0, 0, 64'd0,  5'd0, 0, 64'd0,  1, 1};
  end

  initial begin
    idle_inputs();
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_payload", {53'd0, out_zero, out_ovf, out_op, out_tag}, 64'd0);
    chk("rst_counts", {op_count, ovf_count}, 64'd0);
    chk("rst_status", {61'd0, ovf_sticky, trap_valid, in_ready}, 64'd1);
    chk("rst_trap", {55'd0, trap_op, trap_tag}, 64'd0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      idle_inputs();
      in_valid = tbl[i].iv; out_ready = tbl[i].orr; flush = tbl[i].fl;
      clr_status = tbl[i].clr; alu_out = tbl[i].d; dst_tag = tbl[i].tag;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
      chk($sformatf("tbl%0d_op_count", i), 64'(op_count), 64'(tbl[i].eopc));
      model_step();
      @(posedge clk);
      #1;
    end

    // Overflow entry
    idle_inputs();
    in_valid = 1; alu_ovf = 1; dst_tag = 5'd7; alu_op = 4'd0; alu_out = 64'd9;
    cycle(1);
    idle_inputs();
    @(negedge clk);
    chk("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
    chk("ovf_count_one", 64'(ovf_count), 64'd1);
`ifdef ALU_RESULT_OVF_TRAP_EN
    chk("trap_pulse", 64'(trap_valid), 64'd1);
    chk("trap_tag7", 64'(trap_tag), 64'd7);
    chk("trap_fifo_empty", 64'(out_valid), 64'd0);
`else
    chk("ovf_queued", 64'(out_valid), 64'd1);
    chk("ovf_out_ovf", 64'(out_ovf), 64'd1);
    chk("ovf_out_tag", 64'(out_tag), 64'd7);
`endif
    model_step();
    @(posedge clk);
    #1;
    cycle(1);
    out_ready = 1;
    repeat (2) cycle(1);

    // Counter wrap on the 4-bit instance
    idle_inputs();
    clr_status = 1; out_ready = 1;
    cycle(1);
    clr_status = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; alu_out = 64'(i + 100); dst_tag = 5'(i);
      cycle(1);
    end
    idle_inputs();
    @(negedge clk);
    chk("wrap_op_count4", 64'(op_count4), 64'd0);
    chk("wrap_op_count", 64'(op_count), 64'd16);
    model_step();
    @(posedge clk);
    #1;
    out_ready = 1;
    repeat (2) cycle(1);

    // Reset mid-stream
    idle_inputs();
    in_valid = 1; alu_out = 64'hABCD; dst_tag = 5'd3; alu_ovf = 1;
    cycle(1);
    alu_out = 64'h1234;
    cycle(1);
    idle_inputs();
    #2;
    reset = 1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_payload", {53'd0, out_zero, out_ovf, out_op, out_tag}, 64'd0);
    chk("midrst_counts", {op_count, ovf_count}, 64'd0);
    chk("midrst_sticky", 64'(ovf_sticky), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 19) == 0);
      clr_status = ($urandom_range(0, 29) == 0);
      alu_out    = {$urandom, $urandom};
      alu_zero   = 1'($urandom);
      alu_ovf    = ($urandom_range(0, 3) == 0);
      alu_op     = 4'($urandom);
      dst_tag    = 5'($urandom);
      cycle(1);
    end
    idle_inputs();
    cycle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
